instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: requests the word at pc, buffers the
// response for decode, and follows execute redirects. A misaligned redirect locks it in FAULT.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid, once raised, stays up with stable payload until that edge (redirects excepted).
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fault,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic        discard_q;
   logic        req_valid_q;
   logic        instr_valid_q;
   logic        fault_q;

   logic        redir_ok;
   logic        redir_bad;
   logic [31:0] pc_inc_d;

   assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
   assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign pc_inc_d  = pc_q + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         discard_q     <= 1'b0;
         req_valid_q   <= 1'b1;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else if (state_q != S_FAULT && redir_bad) begin
         // pc is left untouched so the faulting context stays visible on imem_addr
         state_q       <= S_FAULT;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b1;
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (redir_ok) pc_q <= redirect_pc;
               if (imem_req_ready) begin
                  // the old address was accepted, so its data must be thrown away
                  discard_q   <= redir_ok;
                  state_q     <= S_WAIT;
                  req_valid_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (discard_q || redir_ok) begin
                     if (redir_ok) pc_q <= redirect_pc;
                     discard_q   <= 1'b0;
                     state_q     <= S_REQ;
                     req_valid_q <= 1'b1;
                  end else begin
                     instr_q       <= imem_rsp_data;
                     instr_pc_q    <= pc_q;
                     state_q       <= S_HOLD;
                     instr_valid_q <= 1'b1;
                  end
               end else if (redir_ok) begin
                  pc_q      <= redirect_pc;
                  discard_q <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redir_ok || instr_ready) begin
                  pc_q          <= redir_ok ? redirect_pc : pc_inc_d;
                  state_q       <= S_REQ;
                  req_valid_q   <= 1'b1;
                  instr_valid_q <= 1'b0;
               end
            end
            S_FAULT: begin
            end
         endcase
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign instr_valid    = instr_valid_q;
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign fault          = fault_q;
   assign dbg_state_o    = state_q;

   a_req_held : assert property (@(posedge clk) disable iff (!rst_n)
      imem_req_valid && !imem_req_ready && !redirect_valid |=> imem_req_valid && $stable(imem_addr));

   a_valid_in_hold : assert property (@(posedge clk) disable iff (!rst_n)
      instr_valid |-> state_q == S_HOLD);

endmodule
